// File: rtl/flow_led_ctrl.sv
// Flow-LED pattern generator: rotate-left/right, ping-pong and bar-fill, one step per CNT_MAX+1 cycles.
// Define FLOW_LED_ACTIVE_LOW_EN to drive led as the inverse of the pattern (current-sinking LEDs).
module flow_led_ctrl #(
  parameter int LED_NUM = 4,
  parameter     CNT_MAX = 25'd24_999_999,
  parameter int CNT_W   = 25
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [1:0]         mode,
  input  logic               pause,
  output logic [LED_NUM-1:0] led,
  output logic               step
);

  typedef enum logic [1:0] {
    MODE_ROL  = 2'b00,
    MODE_ROR  = 2'b01,
    MODE_PING = 2'b10,
    MODE_BAR  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CNT_MAX);
  localparam logic [LED_NUM-1:0] PAT_LSB  = {{(LED_NUM-1){1'b0}}, 1'b1};
  localparam logic [LED_NUM-1:0] PAT_MSB  = {1'b1, {(LED_NUM-1){1'b0}}};

  logic [CNT_W-1:0]   cnt;
  logic [LED_NUM-1:0] pat;
  logic [LED_NUM-1:0] pat_nxt;
  logic               dir;      // 0 = up (toward MSB), 1 = down
  logic               dir_nxt;
  mode_e              mode_q;
  mode_e              mode_in;
  logic               hit;

  function automatic logic [LED_NUM-1:0] drive(input logic [LED_NUM-1:0] p);
`ifdef FLOW_LED_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  assign mode_in = mode_e'(mode);
  assign hit     = !pause && (cnt == CNT_LAST);

  // Next pattern is only consumed on step cycles; a new mode reloads instead of advancing.
  always_comb begin
    pat_nxt = pat;
    dir_nxt = dir;
    if (mode_in != mode_q) begin
      dir_nxt = 1'b0;
      case (mode_in)
        MODE_ROR: pat_nxt = PAT_MSB;
        default:  pat_nxt = PAT_LSB;
      endcase
    end else begin
      case (mode_q)
        MODE_ROL: pat_nxt = {pat[LED_NUM-2:0], pat[LED_NUM-1]};
        MODE_ROR: pat_nxt = {pat[0], pat[LED_NUM-1:1]};
        MODE_PING: begin
          if (dir) begin
            pat_nxt = pat >> 1;
            if (pat_nxt[0]) dir_nxt = 1'b0;
          end else begin
            pat_nxt = pat << 1;
            if (pat_nxt[LED_NUM-1]) dir_nxt = 1'b1;
          end
        end
        default: pat_nxt = (&pat) ? PAT_LSB : {pat[LED_NUM-2:0], 1'b1};
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      step   <= 1'b0;
      mode_q <= MODE_ROL;
      dir    <= 1'b0;
      pat    <= PAT_LSB;
      led    <= drive(PAT_LSB);
    end else begin
      if (!pause) cnt <= hit ? '0 : cnt + CNT_W'(1);
      step <= hit;
      if (step) begin
        pat    <= pat_nxt;
        dir    <= dir_nxt;
        mode_q <= mode_in;
        led    <= drive(pat_nxt);
      end
    end
  end

endmodule

// File: doc/flow_led_ctrl.md
FLOW_LED_CTRL -- requirements
Module: flow_led_ctrl

Interface
REQ-001 The block SHALL have parameter LED_NUM, default 4, meaning the number of LED outputs; the legal range is 2..32.
REQ-002 The block SHALL have parameter CNT_MAX, default 25'd24_999_999, meaning the last value of the step-interval counter; the legal range is >=1.
REQ-003 The block SHALL have parameter CNT_W, default 25, meaning the step-interval counter width; CNT_W SHALL hold CNT_MAX.
REQ-004 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-006 The block SHALL have port mode, input, 2 bits: pattern select (00 rotate-left, 01 rotate-right, 10 ping-pong, 11 bar-fill).
REQ-007 The block SHALL have port pause, input, 1 bit: when high, the counter and the pattern are frozen.
REQ-008 The block SHALL have port led, output, LED_NUM bits: the LED drive, registered.
REQ-009 The block SHALL have port step, output, 1 bit: a one-cycle pulse that is high in the cycle in which the pattern advances.

Function
REQ-010 The block SHALL advance its interval counter by 1 per cycle while pause=0 and hold it while pause=1.
REQ-011 The block SHALL assert step for exactly one cycle when the counter equals CNT_MAX with pause=0, and clear the counter to 0 in that cycle; the step period is CNT_MAX+1 cycles.
REQ-012 The block SHALL update led only on step cycles; led SHALL show the new pattern on the cycle after step.
REQ-013 The block SHALL sample mode on step cycles only; if the sampled mode differs from the mode held in register mode_q, the pattern SHALL load that mode's initial value instead of advancing, and mode_q SHALL be updated.
REQ-014 The initial value SHALL be bit0 for rotate-left, bit LED_NUM-1 for rotate-right, and bit0 for ping-pong (direction up) and for bar-fill.
REQ-015 In rotate-left, the pattern SHALL shift one-hot toward the MSB on each step, with bit LED_NUM-1 wrapping to bit0.
REQ-016 In rotate-right, the pattern SHALL shift one-hot toward the LSB on each step, with bit0 wrapping to bit LED_NUM-1.
REQ-017 In ping-pong, the one-hot pattern SHALL move in the direction held in register dir; when the lit bit reaches LED_NUM-1 or 0, dir SHALL flip on that same step so the next step moves back, and the end LED SHALL never be lit for two consecutive steps.
REQ-018 In bar-fill, the pattern SHALL evolve as next = {pattern[LED_NUM-2:0],1'b1}; an all-ones pattern SHALL go to bit0-only on the next step.
REQ-019 pause=1 SHALL suppress step even when the counter equals CNT_MAX; counting SHALL resume from the held value when pause returns to 0.
REQ-020 A mode change while pause=1 SHALL take effect at the first step after pause is released.

Reset
REQ-021 With rst_n=0 sampled at a rising edge, the block SHALL set counter=0, step=0, mode_q=00, dir=up, and the internal pattern to bit0 only.
REQ-022 Reset SHALL take priority over pause and step, including mid-interval and mid-sweep.
REQ-023 The first step after reset release SHALL occur CNT_MAX+1 cycles after the first cycle in which rst_n=1.

Configuration
REQ-024 The block SHALL use macro FLOW_LED_ACTIVE_LOW_EN to select the LED drive polarity.
REQ-025 With FLOW_LED_ACTIVE_LOW_EN defined, led SHALL be the bitwise inverse of the internal pattern, for boards whose LEDs sink current; the reset value of led SHALL be ~1.
REQ-026 Without FLOW_LED_ACTIVE_LOW_EN, led SHALL equal the internal pattern; the reset value of led SHALL be 1.
REQ-027 The macro SHALL affect neither step nor timing.

Verification (LED_NUM=4, CNT_MAX=9, 20 ns clock, macro undefined unless stated)
REQ-028 Reset and rotate: hold rst_n=0 for 50 ns, then release with mode=00 -> led=0001; step pulses every 200 ns; led sequence 0010,0100,1000,0001.
REQ-029 Ping-pong: mode=10 from reset -> first step reloads 0001, then 0010,0100,1000,0100,0010,0001,0010; 1000 never appears twice in a row.
REQ-030 Bar-fill plus mode switch: mode=11 -> 0001,0011,0111,1111,0001; switching to mode=01 mid-interval -> next step loads 1000, then 0100.
REQ-031 Pause: assert pause for 500 ns mid-interval -> no step and led frozen; after release, the next step comes after the remaining (10 - elapsed) cycles.
REQ-032 Reset mid-operation: drive rst_n=0 for 1 cycle while led=0100 in ping-pong down direction -> led=0001, dir=up, counter=0; after release the first step comes after 10 cycles and loads 0001.
REQ-033 Macro: build with FLOW_LED_ACTIVE_LOW_EN and rerun the REQ-028 scenario -> led reads 1110,1101,1011,0111,1110, and step timing is identical.
